fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, width of PC and instruction-memory address.
REQ-002 SHALL have parameter INSTR_WIDTH, 32, instruction word width.
REQ-003 SHALL have parameter QUEUE_DEPTH, 4, prefetch queue entries; power of 2, >= 2.
REQ-004 SHALL have parameter NOP_INSTR, 32'h21000000, word driven on `instruction` when no valid instruction is present.
REQ-005 SHALL have one clock and a synchronous, active-high reset: ports `clock` and `reset`.
REQ-006 SHALL have ports: clock  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: imem_req  out  1  fetch request; imem_addr  out  ADDR_WIDTH  fetch address (= pc).
REQ-008 SHALL have ports: imem_instr  in  INSTR_WIDTH  fetched word, valid in the same cycle when imem_stall=0; imem_stall  in  1  memory not ready.
REQ-009 SHALL have ports: id_stall  in  1  decode cannot accept; branch_taken  in  1  redirect; new_pc  in  ADDR_WIDTH  redirect target.
REQ-010 SHALL have ports: instr_valid  out  1; instruction  out  INSTR_WIDTH; prog_counter  out  ADDR_WIDTH; queue_count  out  $clog2(QUEUE_DEPTH+1)  queue occupancy.

Function
REQ-011 SHALL hold a pc register, a QUEUE_DEPTH-entry FIFO of {pc, instr} with wrap-around read/write pointers, and a registered output stage (instr_valid, instruction, prog_counter).
REQ-012 SHALL assert imem_req when reset=0, branch_taken=0, and a queue slot is free after this cycle's pop (count < QUEUE_DEPTH, or count = QUEUE_DEPTH with a pop this cycle).
REQ-013 SHALL define fetch-accept as imem_req & ~imem_stall; on accept, push {pc, imem_instr} and set pc <= pc+1 (modulo 2^ADDR_WIDTH).
REQ-014 SHALL hold pc and push nothing while imem_stall=1.
REQ-015 SHALL define output-load as (~instr_valid | ~id_stall); when output-load is true and the queue is non-empty, pop the head into the output stage with instr_valid <= 1.
REQ-016 SHALL, when output-load is true and there is no instruction to load, set instr_valid <= 0 and instruction <= NOP_INSTR.
REQ-017 SHALL hold the output stage unchanged while instr_valid=1 and id_stall=1.
REQ-018 SHALL, on branch_taken=1 (priority over id_stall and imem_stall): pc <= new_pc, empty the queue (count 0, pointers equal), discard any same-cycle fetch, and set instr_valid <= 0, instruction <= NOP_INSTR.
REQ-019 SHALL allow a simultaneous push and pop on a full queue, leaving count unchanged.
REQ-020 SHALL keep queue_count equal to the number of stored entries, never exceeding QUEUE_DEPTH.
REQ-021 SHALL produce no push when the queue is full and there is no pop.

Reset
REQ-022 SHALL, on reset=1 at a clock edge: pc <= 0, queue emptied, instr_valid <= 0, instruction <= NOP_INSTR, prog_counter <= 0, queue_count <= 0.
REQ-023 SHALL hold imem_req=0 during reset, regardless of any pending fetch or stall.

Configuration
REQ-024 SHALL implement the macro FETCH_BYPASS_EN.
REQ-025 SHALL, with FETCH_BYPASS_EN defined, load an accepted fetch directly into the output stage, skipping the queue, when the queue is empty, output-load is true and branch_taken=0; fetch-to-output latency is 1 cycle.
REQ-026 SHALL, without FETCH_BYPASS_EN, route every fetch through the queue; fetch-to-output latency is 2 cycles.
REQ-027 SHALL, in both configurations, deliver the identical instruction sequence; only latency differs.

Verification
REQ-028 Reset release, imem_stall=0, id_stall=0, imem_instr=pc-indexed -> without bypass: instr_valid=1, prog_counter=0 at the 2nd edge after release, then pc 1, 2, 3 on consecutive cycles; with bypass: at the 1st edge.
REQ-029 id_stall=1 held 10 cycles -> output frozen; queue_count saturates at QUEUE_DEPTH=4; imem_req=0 while full; on release, the next outputs are pc+1..pc+4 with no gap or duplicate.
REQ-030 branch_taken=1, new_pc=0x100, with the queue holding 3 entries -> next cycle instr_valid=0, instruction=0x21000000, queue_count=0; the first valid output afterwards has prog_counter=0x100.
REQ-031 imem_stall=1 for 3 cycles at pc=5 -> pc stays 5, no pushes; after release, outputs continue with prog_counter=5 with no lost entries.
REQ-032 Full queue, id_stall=0, imem_stall=0 -> push and pop in the same cycle; queue_count stays 4; pointers wrap past index 3 correctly over 20 cycles.
REQ-033 reset=1 asserted mid-stream with the queue holding 2 entries -> next cycle all state is as in REQ-022; fetch restarts from pc=0.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Holds the PC, prefetches words into
//                a QUEUE_DEPTH-entry {pc, instr} FIFO and presents them to
//                decode through a registered output stage. branch_taken
//                redirects the PC and flushes everything in flight.
//  Options     : FETCH_BYPASS_EN - when defined, a fetch that finds the queue
//                empty and the output stage free goes straight to the output
//                stage (1-cycle fetch-to-output instead of 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                     ADDR_WIDTH  = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     QUEUE_DEPTH = 4,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h21000000
) (
  input  logic                               clock,
  input  logic                               reset,
  // instruction memory side
  output logic                               imem_req,
  output logic [ADDR_WIDTH-1:0]              imem_addr,
  input  logic [INSTR_WIDTH-1:0]             imem_instr,
  input  logic                               imem_stall,
  // decode side
  input  logic                               id_stall,
  input  logic                               branch_taken,
  input  logic [ADDR_WIDTH-1:0]              new_pc,
  output logic                               instr_valid,
  output logic [INSTR_WIDTH-1:0]             instruction,
  output logic [ADDR_WIDTH-1:0]              prog_counter,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
);

  localparam int c_ptr_w = $clog2(QUEUE_DEPTH);
  localparam int c_cnt_w = $clog2(QUEUE_DEPTH + 1);

  localparam logic [c_cnt_w-1:0]    c_cnt_full = c_cnt_w'(QUEUE_DEPTH);
  localparam logic [c_cnt_w-1:0]    c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0]    c_ptr_one  = c_ptr_w'(1);
  localparam logic [ADDR_WIDTH-1:0] c_pc_one   = ADDR_WIDTH'(1);

  // architectural state
  logic [ADDR_WIDTH-1:0]  pc_q,      pc_d;
  logic [c_ptr_w-1:0]     wr_ptr_q,  wr_ptr_d;
  logic [c_ptr_w-1:0]     rd_ptr_q,  rd_ptr_d;
  logic [c_cnt_w-1:0]     count_q,   count_d;
  logic                   valid_q,   valid_d;
  logic [INSTR_WIDTH-1:0] instr_q,   instr_d;
  logic [ADDR_WIDTH-1:0]  pc_out_q,  pc_out_d;

  // prefetch storage (data only, no reset needed: occupancy is tracked by count_q)
  logic [ADDR_WIDTH-1:0]  q_pc_mem    [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] q_instr_mem [QUEUE_DEPTH];

  // per-cycle control decisions
  logic q_empty;
  logic q_full;
  logic out_load;
  logic pop;
  logic fetch_req;
  logic fetch_acc;
  logic bypass;
  logic push;

  // Handshake decisions: pop, fetch request/accept, bypass and push for this cycle
  always_comb begin
    q_empty   = (count_q == '0);
    q_full    = (count_q == c_cnt_full);
    out_load  = ~valid_q | ~id_stall;
    // A redirect flushes the queue, so nothing is popped on a branch cycle.
    pop       = out_load & ~q_empty & ~branch_taken;
    // A full queue may still fetch when the head leaves in the same cycle.
    fetch_req = ~reset & ~branch_taken & (~q_full | pop);
    fetch_acc = fetch_req & ~imem_stall;
`ifdef FETCH_BYPASS_EN
    bypass    = fetch_acc & q_empty & out_load;
`else
    bypass    = 1'b0;
`endif
    push      = fetch_acc & ~bypass;
  end

  // Next-state computation for PC, queue bookkeeping and the output stage
  always_comb begin
    pc_d     = fetch_acc ? (pc_q + c_pc_one) : pc_q;
    wr_ptr_d = push ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;

    if (branch_taken) begin
      pc_d     = new_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      instr_d  = NOP_INSTR;
    end else if (out_load) begin
      if (pop) begin
        valid_d  = 1'b1;
        instr_d  = q_instr_mem[rd_ptr_q];
        pc_out_d = q_pc_mem[rd_ptr_q];
      end else if (bypass) begin
        valid_d  = 1'b1;
        instr_d  = imem_instr;
        pc_out_d = pc_q;
      end else begin
        valid_d  = 1'b0;
        instr_d  = NOP_INSTR;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      pc_out_q <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  // Queue write port: store the accepted fetch at the tail
  always_ff @(posedge clock) begin
    if (push) begin
      q_pc_mem[wr_ptr_q]    <= pc_q;
      q_instr_mem[wr_ptr_q] <= imem_instr;
    end
  end

  assign imem_req     = fetch_req;
  assign imem_addr    = pc_q;
  assign instr_valid  = valid_q;
  assign instruction  = instr_q;
  assign prog_counter = pc_out_q;
  assign queue_count  = count_q;

endmodule
`default_nettype wire
